// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer followed by a four-state
// qualification FSM that emits a debounced level plus one-cycle press/release pulses.
module btn_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 16
) (
    input  logic clk,
    input  logic n_rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press,
    output logic release_pulse
);

    localparam logic [1:0] S_LOW  = 2'd0;
    localparam logic [1:0] S_RISE = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_FALL = 2'd3;

    localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DB_CYCLES);
    localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

    logic            sync_0;
    logic            sync_1;
    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic [DB_W-1:0] cnt_reg;
    logic [DB_W-1:0] cnt_next;
    logic            level_next;
    logic            press_next;
    logic            release_next;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync_0        <= 1'b0;
            sync_1        <= 1'b0;
            state_reg     <= S_LOW;
            cnt_reg       <= '0;
            btn_level     <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_0        <= btn_in;
            sync_1        <= sync_0;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            btn_level     <= level_next;
            press         <= press_next;
            release_pulse <= release_next;
        end
    end

    // The >= test on cnt_reg is a belt-and-braces guard: the counter can
    // never step past DB_LIMIT even if it were somehow corrupted.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        level_next   = btn_level;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state_reg)
            S_LOW: begin
                if (sync_1) begin
                    state_next = S_RISE;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            S_RISE: begin
                if (!sync_1) begin
                    state_next = S_LOW;
                    cnt_next   = '0;
                end else if (cnt_reg >= DB_LIMIT) begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync_1) begin
                    state_next = S_FALL;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            S_FALL: begin
                if (sync_1) begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg >= DB_LIMIT) begin
                    state_next   = S_LOW;
                    cnt_next     = '0;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    cnt_next     = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = S_LOW;
                cnt_next   = '0;
                level_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (DB_CYCLES=4): reset, clean edges, bounce,
// reset during qualification, and a random bounce soak checking pulse rules.
module tb_btn_debounce;

    logic clk;
    logic n_rst;
    logic btn_in;
    logic btn_level;
    logic press;
    logic release_pulse;

    int checks;
    int passed;

    btn_debounce #(.DB_CYCLES(4), .DB_W(16)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press         (press),
        .release_pulse (release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk3(input string tag, input logic lvl, input logic p, input logic r);
        chk({tag, ".level"}, 32'(btn_level), 32'(lvl));
        chk({tag, ".press"}, 32'(press), 32'(p));
        chk({tag, ".release"}, 32'(release_pulse), 32'(r));
    endtask

    int hold;
    int cyc;
    int last_pulse;   // 0 none yet, 1 press, 2 release
    int n_press;
    logic prev_press;
    logic prev_rel;

    initial begin
        checks = 0;
        passed = 0;
        n_rst  = 1'b0;
        btn_in = 1'b0;

        // Reset held 3 edges with btn_in toggling
        for (int i = 0; i < 3; i++) begin
            btn_in = ~btn_in;
            tick();
            chk3("reset_hold", 1'b0, 1'b0, 1'b0);
        end
        n_rst  = 1'b1;
        btn_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk3("after_reset", 1'b0, 1'b0, 1'b0);
        end

        // Clean rise: level/press after edge k+6
        btn_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk3("rise_wait", 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk3("rise_accept", 1'b1, 1'b1, 1'b0);
        tick();
        chk3("rise_after", 1'b1, 1'b0, 1'b0);
        tick();

        // Clean fall: release after edge m+6
        btn_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk3("fall_wait", 1'b1, 1'b0, 1'b0);
        end
        tick();
        chk3("fall_accept", 1'b0, 1'b0, 1'b1);
        tick();
        chk3("fall_after", 1'b0, 1'b0, 1'b0);
        tick();

        // Bounce: 3 high / 3 low, five times, never accepted
        for (int b = 0; b < 5; b++) begin
            btn_in = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk3("bounce_hi", 1'b0, 1'b0, 1'b0);
            end
            btn_in = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk3("bounce_lo", 1'b0, 1'b0, 1'b0);
            end
        end
        btn_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk3("bounce_final_wait", 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk3("bounce_final_press", 1'b1, 1'b1, 1'b0);
        tick();
        chk3("bounce_final_after", 1'b1, 1'b0, 1'b0);

        // Return low and settle
        btn_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk3("settle_low", 1'b0, 1'b0, 1'b0);

        // Reset while in S_RISE with cnt=3, button kept high
        btn_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk3("pre_abort", 1'b0, 1'b0, 1'b0);
        n_rst = 1'b0;
        tick();
        chk3("abort_reset", 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk3("requal_wait", 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk3("requal_press", 1'b1, 1'b1, 1'b0);
        tick();
        chk3("requal_after", 1'b1, 1'b0, 1'b0);

        // Random bounce soak from a clean reset
        n_rst  = 1'b0;
        btn_in = 1'b0;
        tick();
        n_rst  = 1'b1;
        last_pulse = 0;
        n_press    = 0;
        prev_press = 1'b0;
        prev_rel   = 1'b0;
        cyc = 0;
        while (cyc < 10000) begin
            btn_in = ~btn_in;
            hold   = int'($urandom_range(1, 12));
            for (int i = 0; i < hold && cyc < 10000; i++) begin
                tick();
                cyc++;
                chk("soak_not_both", 32'(press & release_pulse), 32'd0);
                if (press) begin
                    n_press++;
                    chk("soak_press_width", 32'(prev_press), 32'd0);
                    chk("soak_press_order", 32'(last_pulse == 1), 32'd0);
                    last_pulse = 1;
                end
                if (release_pulse) begin
                    chk("soak_release_width", 32'(prev_rel), 32'd0);
                    chk("soak_release_order", 32'(last_pulse == 1), 32'd1);
                    last_pulse = 2;
                end
                prev_press = press;
                prev_rel   = release_pulse;
            end
        end
        chk("soak_saw_press", 32'(n_press > 0), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
